// File: rtl/slb_unit_pkg.sv
// Shared definitions for the store/load buffer: bus widths, opcodes,
// access-size encodings and controller states.
package slb_unit_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int NICK_BUS_W = 5;
  localparam int OP_BUS_W   = 6;

  localparam logic [OP_BUS_W-1:0] OP_LB  = 6'd1;
  localparam logic [OP_BUS_W-1:0] OP_LH  = 6'd2;
  localparam logic [OP_BUS_W-1:0] OP_LW  = 6'd3;
  localparam logic [OP_BUS_W-1:0] OP_LBU = 6'd4;
  localparam logic [OP_BUS_W-1:0] OP_LHU = 6'd5;
  localparam logic [OP_BUS_W-1:0] OP_SB  = 6'd6;
  localparam logic [OP_BUS_W-1:0] OP_SH  = 6'd7;
  localparam logic [OP_BUS_W-1:0] OP_SW  = 6'd8;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    DRAIN    = 2'd2
  } slb_state_e;

  function automatic logic op_is_store(input logic [OP_BUS_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] op_len(input logic [OP_BUS_W-1:0] op);
    logic [1:0] len;
    case (op)
      OP_LB, OP_LBU, OP_SB: len = LEN_BYTE;
      OP_LH, OP_LHU, OP_SH: len = LEN_HALF;
      default:              len = LEN_WORD;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/slb_load_ext.sv
// Sign/zero extension of raw memory read data according to the load opcode.
module slb_load_ext
  import slb_unit_pkg::*;
#(
  parameter int OP_W = OP_BUS_W
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] dt
);

  always_comb begin
    dt = raw;
    case (op)
      OP_LB:   dt = {{24{raw[7]}}, raw[7:0]};
      OP_LH:   dt = {{16{raw[15]}}, raw[15:0]};
      OP_LBU:  dt = {24'd0, raw[7:0]};
      OP_LHU:  dt = {16'd0, raw[15:0]};
      default: dt = raw;
    endcase
  end

endmodule

// File: rtl/slb_unit.sv
// Store/load buffer: in-order FIFO of memory micro-ops that snoops operand
// broadcasts, issues the head to the memory controller and reports to the ROB.
module slb_unit
  import slb_unit_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int NICK_W = 5,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              iclr,
  output logic              oINF_full,
  input  logic              iDP_en,
  input  logic [OP_W-1:0]   iDP_op,
  input  logic [NICK_W-1:0] iDP_nick,
  input  logic [31:0]       iDP_imm,
  input  logic [31:0]       iDP_rs1_dt,
  input  logic [31:0]       iDP_rs2_dt,
  input  logic [NICK_W-1:0] iDP_rs1_nick,
  input  logic [NICK_W-1:0] iDP_rs2_nick,
  input  logic              iEX_en,
  input  logic [NICK_W-1:0] iEX_nick,
  input  logic [31:0]       iEX_dt,
  input  logic              iROB_store_en,
  input  logic [NICK_W-1:0] iROB_store_nick,
  output logic              oROB_en,
  output logic [NICK_W-1:0] oROB_nick,
  output logic [31:0]       oROB_dt,
  output logic              oMC_en,
  output logic              oMC_wr,
  output logic [31:0]       oMC_addr,
  output logic [31:0]       oMC_dt,
  output logic [1:0]        oMC_len,
  input  logic              iMC_done,
  input  logic [31:0]       iMC_dt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_committed;
  logic [OP_W-1:0]   ent_op       [DEPTH];
  logic [NICK_W-1:0] ent_nick     [DEPTH];
  logic [31:0]       ent_imm      [DEPTH];
  logic [31:0]       ent_rs1_dt   [DEPTH];
  logic [NICK_W-1:0] ent_rs1_nick [DEPTH];
  logic [31:0]       ent_rs2_dt   [DEPTH];
  logic [NICK_W-1:0] ent_rs2_nick [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count, count_next;

  slb_state_e state, state_next;
  logic head_ready, issue, retire, dispatch_fire;
  logic head_store;
  logic [31:0] load_dt;

  function automatic logic nick_hit(input logic [NICK_W-1:0] nick,
                                    input logic              bc_en,
                                    input logic [NICK_W-1:0] bc_nick);
    return bc_en && (nick != '0) && (nick == bc_nick);
  endfunction

  slb_load_ext #(.OP_W(OP_W)) u_load_ext (
    .op  (ent_op[head]),
    .raw (iMC_dt),
    .dt  (load_dt)
  );

  assign head_store = op_is_store(ent_op[head]);
  assign head_ready = ent_valid[head] && (ent_rs1_nick[head] == '0) &&
                      (!head_store || ((ent_rs2_nick[head] == '0) && ent_committed[head]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= IDLE;
    else if (rdy) state <= state_next;
  end

  // A flush during an outstanding access drains it silently through DRAIN.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        if (!iclr && head_ready) begin
          issue      = 1'b1;
          state_next = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (iclr) begin
          state_next = iMC_done ? IDLE : DRAIN;
        end else if (iMC_done) begin
          retire     = 1'b1;
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (iMC_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dispatch_fire = iDP_en && !oINF_full && !iclr && (state != DRAIN);
    count_next    = count;
    if (iclr) begin
      count_next = '0;
    end else begin
      case ({dispatch_fire, retire})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid     <= '0;
      ent_committed <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_op[i]       <= '0;
        ent_nick[i]     <= '0;
        ent_imm[i]      <= '0;
        ent_rs1_dt[i]   <= '0;
        ent_rs1_nick[i] <= '0;
        ent_rs2_dt[i]   <= '0;
        ent_rs2_nick[i] <= '0;
      end
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      oINF_full <= 1'b0;
      oROB_en   <= 1'b0;
      oROB_nick <= '0;
      oROB_dt   <= '0;
      oMC_en    <= 1'b0;
      oMC_wr    <= 1'b0;
      oMC_addr  <= '0;
      oMC_dt    <= '0;
      oMC_len   <= '0;
    end else if (rdy) begin
      oROB_en   <= 1'b0;
      count     <= count_next;
      oINF_full <= (count_next == FULL_CNT);

      if (iclr) begin
        ent_valid     <= '0;
        ent_committed <= '0;
        head          <= '0;
        tail          <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_valid[i]) begin
            if (nick_hit(ent_rs1_nick[i], iEX_en, iEX_nick)) begin
              ent_rs1_dt[i]   <= iEX_dt;
              ent_rs1_nick[i] <= '0;
            end else if (nick_hit(ent_rs1_nick[i], oROB_en, oROB_nick)) begin
              ent_rs1_dt[i]   <= oROB_dt;
              ent_rs1_nick[i] <= '0;
            end
            if (nick_hit(ent_rs2_nick[i], iEX_en, iEX_nick)) begin
              ent_rs2_dt[i]   <= iEX_dt;
              ent_rs2_nick[i] <= '0;
            end else if (nick_hit(ent_rs2_nick[i], oROB_en, oROB_nick)) begin
              ent_rs2_dt[i]   <= oROB_dt;
              ent_rs2_nick[i] <= '0;
            end
            if (iROB_store_en && op_is_store(ent_op[i]) && (ent_nick[i] == iROB_store_nick))
              ent_committed[i] <= 1'b1;
          end
        end

        // Operands broadcast in the dispatch cycle are captured directly.
        if (dispatch_fire) begin
          ent_valid[tail]     <= 1'b1;
          ent_op[tail]        <= iDP_op;
          ent_nick[tail]      <= iDP_nick;
          ent_imm[tail]       <= iDP_imm;
          ent_committed[tail] <= iROB_store_en && op_is_store(iDP_op) &&
                                 (iDP_nick == iROB_store_nick);
          if (nick_hit(iDP_rs1_nick, iEX_en, iEX_nick)) begin
            ent_rs1_dt[tail]   <= iEX_dt;
            ent_rs1_nick[tail] <= '0;
          end else if (nick_hit(iDP_rs1_nick, oROB_en, oROB_nick)) begin
            ent_rs1_dt[tail]   <= oROB_dt;
            ent_rs1_nick[tail] <= '0;
          end else begin
            ent_rs1_dt[tail]   <= iDP_rs1_dt;
            ent_rs1_nick[tail] <= iDP_rs1_nick;
          end
          if (nick_hit(iDP_rs2_nick, iEX_en, iEX_nick)) begin
            ent_rs2_dt[tail]   <= iEX_dt;
            ent_rs2_nick[tail] <= '0;
          end else if (nick_hit(iDP_rs2_nick, oROB_en, oROB_nick)) begin
            ent_rs2_dt[tail]   <= oROB_dt;
            ent_rs2_nick[tail] <= '0;
          end else begin
            ent_rs2_dt[tail]   <= iDP_rs2_dt;
            ent_rs2_nick[tail] <= iDP_rs2_nick;
          end
          tail <= tail + 1'b1;
        end

        if (retire) begin
          ent_valid[head]     <= 1'b0;
          ent_committed[head] <= 1'b0;
          head                <= head + 1'b1;
          oROB_en             <= 1'b1;
          oROB_nick           <= ent_nick[head];
          oROB_dt             <= head_store ? 32'd0 : load_dt;
        end
      end

      if (issue) begin
        oMC_en   <= 1'b1;
        oMC_wr   <= head_store;
        oMC_addr <= ent_rs1_dt[head] + ent_imm[head];
        oMC_dt   <= ent_rs2_dt[head];
        oMC_len  <= op_len(ent_op[head]);
      end else if ((state != IDLE) && iMC_done) begin
        oMC_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_slb_unit.sv
// Directed self-checking bench for slb_unit: loads, stores with commit,
// fill/wrap, flush drain, dispatch-time forwarding and the global enable.
module tb_slb_unit;
  import slb_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        iclr;
  logic        oINF_full;
  logic        iDP_en;
  logic [5:0]  iDP_op;
  logic [4:0]  iDP_nick;
  logic [31:0] iDP_imm;
  logic [31:0] iDP_rs1_dt, iDP_rs2_dt;
  logic [4:0]  iDP_rs1_nick, iDP_rs2_nick;
  logic        iEX_en;
  logic [4:0]  iEX_nick;
  logic [31:0] iEX_dt;
  logic        iROB_store_en;
  logic [4:0]  iROB_store_nick;
  logic        oROB_en;
  logic [4:0]  oROB_nick;
  logic [31:0] oROB_dt;
  logic        oMC_en, oMC_wr;
  logic [31:0] oMC_addr, oMC_dt;
  logic [1:0]  oMC_len;
  logic        iMC_done;
  logic [31:0] iMC_dt;

  int tests_run    = 0;
  int tests_failed = 0;

  slb_unit #(.DEPTH(16), .NICK_W(5), .OP_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .iclr(iclr), .oINF_full(oINF_full),
    .iDP_en(iDP_en), .iDP_op(iDP_op), .iDP_nick(iDP_nick), .iDP_imm(iDP_imm),
    .iDP_rs1_dt(iDP_rs1_dt), .iDP_rs2_dt(iDP_rs2_dt),
    .iDP_rs1_nick(iDP_rs1_nick), .iDP_rs2_nick(iDP_rs2_nick),
    .iEX_en(iEX_en), .iEX_nick(iEX_nick), .iEX_dt(iEX_dt),
    .iROB_store_en(iROB_store_en), .iROB_store_nick(iROB_store_nick),
    .oROB_en(oROB_en), .oROB_nick(oROB_nick), .oROB_dt(oROB_dt),
    .oMC_en(oMC_en), .oMC_wr(oMC_wr), .oMC_addr(oMC_addr), .oMC_dt(oMC_dt),
    .oMC_len(oMC_len), .iMC_done(iMC_done), .iMC_dt(iMC_dt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [5:0] op, input logic [4:0] nick, input logic [31:0] imm,
                          input logic [31:0] rs1_dt, input logic [4:0] rs1_nick,
                          input logic [31:0] rs2_dt, input logic [4:0] rs2_nick);
    iDP_op = op; iDP_nick = nick; iDP_imm = imm;
    iDP_rs1_dt = rs1_dt; iDP_rs1_nick = rs1_nick;
    iDP_rs2_dt = rs2_dt; iDP_rs2_nick = rs2_nick;
    iDP_en = 1'b1;
    tick();
    iDP_en = 1'b0;
  endtask

  // Waits (bounded) for a request, records it, answers with a one-cycle done.
  // Returns one cycle after the done edge, when the ROB pulse is visible.
  task automatic mem_respond(input int max_wait, input logic [31:0] rdata, output bit ok,
                             output logic [31:0] addr, output logic wr,
                             output logic [1:0] len, output logic [31:0] wdt);
    int waited = 0;
    ok = 1'b0;
    addr = '0; wr = 1'b0; len = '0; wdt = '0;
    while (!oMC_en && waited < max_wait) begin
      tick();
      waited++;
    end
    if (oMC_en) begin
      ok = 1'b1;
      addr = oMC_addr; wr = oMC_wr; len = oMC_len; wdt = oMC_dt;
      iMC_dt = rdata;
      iMC_done = 1'b1;
      tick();
      iMC_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; iclr = 1'b0; iDP_en = 1'b0; iDP_op = '0; iDP_nick = '0;
    iDP_imm = '0; iDP_rs1_dt = '0; iDP_rs2_dt = '0; iDP_rs1_nick = '0; iDP_rs2_nick = '0;
    iEX_en = 1'b0; iEX_nick = '0; iEX_dt = '0; iROB_store_en = 1'b0; iROB_store_nick = '0;
    iMC_done = 1'b0; iMC_dt = '0;
    #3;
    tests_run++;
    if ({oINF_full, oROB_en, oMC_en, oMC_wr} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {oINF_full, oROB_en, oMC_en, oMC_wr});
    end
    tests_run++;
    if ({oMC_addr, oMC_dt, oROB_dt, oROB_nick, oMC_len} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_buses: addr %h dt %h robdt %h nick %0d len %0d expected all 0",
               oMC_addr, oMC_dt, oROB_dt, oROB_nick, oMC_len);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lw();
    bit ok; logic [31:0] a, d; logic w; logic [1:0] l;
    dispatch(OP_LW, 5'd3, 32'd4, 32'h100, 5'd0, 32'd0, 5'd0);
    mem_respond(10, 32'hDEADBEEF, ok, a, w, l, d);
    tests_run++;
    if (!ok || a !== 32'h104 || l !== LEN_WORD || w !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lw_request: ok %0b addr %h len %0d wr %0b expected 1 00000104 2 0", ok, a, l, w);
    end
    tests_run++;
    if (oROB_en !== 1'b1 || oROB_nick !== 5'd3 || oROB_dt !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("[TB] FAIL lw_result: en %0b nick %0d dt %h expected 1 3 deadbeef", oROB_en, oROB_nick, oROB_dt);
    end
    tick();
    tests_run++;
    if (oROB_en !== 1'b0 || oMC_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lw_single_pulse: rob_en %0b mc_en %0b expected 0 0", oROB_en, oMC_en);
    end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [31:0] a, d; logic w; logic [1:0] l;
    dispatch(OP_LB, 5'd4, 32'hFFFFFFFF, 32'h200, 5'd0, 32'd0, 5'd0);
    dispatch(OP_LBU, 5'd6, 32'd2, 32'h200, 5'd0, 32'd0, 5'd0);
    mem_respond(10, 32'h00000080, ok, a, w, l, d);
    tests_run++;
    if (!ok || a !== 32'h1FF || l !== LEN_BYTE) begin
      tests_failed++;
      $display("[TB] FAIL lb_request: ok %0b addr %h len %0d expected 1 000001ff 0", ok, a, l);
    end
    tests_run++;
    if (oROB_en !== 1'b1 || oROB_nick !== 5'd4 || oROB_dt !== 32'hFFFFFF80) begin
      tests_failed++;
      $display("[TB] FAIL lb_result: en %0b nick %0d dt %h expected 1 4 ffffff80", oROB_en, oROB_nick, oROB_dt);
    end
    mem_respond(10, 32'h00000080, ok, a, w, l, d);
    tests_run++;
    if (!ok || a !== 32'h202 || l !== LEN_BYTE) begin
      tests_failed++;
      $display("[TB] FAIL lbu_request: ok %0b addr %h len %0d expected 1 00000202 0", ok, a, l);
    end
    tests_run++;
    if (oROB_en !== 1'b1 || oROB_nick !== 5'd6 || oROB_dt !== 32'h00000080) begin
      tests_failed++;
      $display("[TB] FAIL lbu_result: en %0b nick %0d dt %h expected 1 6 00000080", oROB_en, oROB_nick, oROB_dt);
    end
    tick();
  endtask

  task automatic test_store();
    bit ok; bit early; logic [31:0] a, d; logic w; logic [1:0] l;
    early = 1'b0;
    dispatch(OP_SW, 5'd5, 32'd8, 32'h300, 5'd0, 32'hBAD0BAD0, 5'd2);
    iEX_en = 1'b1; iEX_nick = 5'd2; iEX_dt = 32'h55;
    tick();
    iEX_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (oMC_en) early = 1'b1;
      tick();
    end
    tests_run++;
    if (early) begin
      tests_failed++;
      $display("[TB] FAIL store_waits_commit: got request before commit, expected none");
    end
    iROB_store_en = 1'b1; iROB_store_nick = 5'd5;
    mem_respond(10, 32'hFFFFFFFF, ok, a, w, l, d);
    tests_run++;
    if (!ok || a !== 32'h308 || w !== 1'b1 || d !== 32'h55 || l !== LEN_WORD) begin
      tests_failed++;
      $display("[TB] FAIL sw_request: ok %0b addr %h wr %0b dt %h len %0d expected 1 00000308 1 00000055 2",
               ok, a, w, d, l);
    end
    tests_run++;
    if (oROB_en !== 1'b1 || oROB_nick !== 5'd5 || oROB_dt !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL sw_ack: en %0b nick %0d dt %h expected 1 5 00000000", oROB_en, oROB_nick, oROB_dt);
    end
    iROB_store_en = 1'b0;
    mem_respond(5, 32'd0, ok, a, w, l, d);
    tests_run++;
    if (ok) begin
      tests_failed++;
      $display("[TB] FAIL sw_single_write: got extra request addr %h, expected none", a);
    end
  endtask

  task automatic test_forward();
    bit ok; logic [31:0] a, d; logic w; logic [1:0] l;
    iEX_en = 1'b1; iEX_nick = 5'd7; iEX_dt = 32'h700;
    dispatch(OP_LH, 5'd15, 32'h10, 32'h0, 5'd7, 32'd0, 5'd0);
    iEX_en = 1'b0;
    tick();
    tests_run++;
    if (oMC_en !== 1'b1 || oMC_addr !== 32'h710 || oMC_len !== LEN_HALF) begin
      tests_failed++;
      $display("[TB] FAIL forward_issue: en %0b addr %h len %0d expected 1 00000710 1", oMC_en, oMC_addr, oMC_len);
    end
    mem_respond(2, 32'h12348001, ok, a, w, l, d);
    tests_run++;
    if (!ok || oROB_en !== 1'b1 || oROB_nick !== 5'd15 || oROB_dt !== 32'hFFFF8001) begin
      tests_failed++;
      $display("[TB] FAIL lh_result: ok %0b en %0b nick %0d dt %h expected 1 1 15 ffff8001",
               ok, oROB_en, oROB_nick, oROB_dt);
    end
    tick();
  endtask

  task automatic test_clear();
    bit ok; logic [31:0] a, d; logic w; logic [1:0] l;
    dispatch(OP_LW, 5'd12, 32'd0, 32'h500, 5'd0, 32'd0, 5'd0);
    tick();
    tests_run++;
    if (oMC_en !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL clr_pre_issue: mc_en %0b expected 1", oMC_en);
    end
    iclr = 1'b1;
    tick();
    iclr = 1'b0;
    dispatch(OP_LW, 5'd13, 32'd0, 32'h800, 5'd0, 32'd0, 5'd0);
    tick();
    tests_run++;
    if (oMC_en !== 1'b1 || oMC_addr !== 32'h500 || oROB_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clr_drain_hold: mc_en %0b addr %h rob_en %0b expected 1 00000500 0",
               oMC_en, oMC_addr, oROB_en);
    end
    iMC_dt = 32'h1234; iMC_done = 1'b1;
    tick();
    iMC_done = 1'b0;
    tests_run++;
    if (oROB_en !== 1'b0 || oMC_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clr_discard: rob_en %0b mc_en %0b expected 0 0", oROB_en, oMC_en);
    end
    dispatch(OP_LW, 5'd14, 32'd0, 32'h600, 5'd0, 32'd0, 5'd0);
    mem_respond(10, 32'hCAFE0001, ok, a, w, l, d);
    tests_run++;
    if (!ok || a !== 32'h600 || oROB_en !== 1'b1 || oROB_nick !== 5'd14 || oROB_dt !== 32'hCAFE0001) begin
      tests_failed++;
      $display("[TB] FAIL clr_after: ok %0b addr %h en %0b nick %0d dt %h expected 1 00000600 1 14 cafe0001",
               ok, a, oROB_en, oROB_nick, oROB_dt);
    end
    mem_respond(5, 32'd0, ok, a, w, l, d);
    tests_run++;
    if (ok) begin
      tests_failed++;
      $display("[TB] FAIL clr_drain_dispatch: got request addr %h, expected none", a);
    end
  endtask

  task automatic test_full();
    bit ok; logic [31:0] a, d; logic w; logic [1:0] l;
    for (int k = 0; k < 16; k++) begin
      dispatch(OP_LW, 5'(10 + k), 32'(4 * k), 32'h0, 5'd9, 32'd0, 5'd0);
      if (k == 14) begin
        tests_run++;
        if (oINF_full !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL full_early: got %0b expected 0", oINF_full);
        end
      end
    end
    tests_run++;
    if (oINF_full !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL full_set: got %0b expected 1", oINF_full);
    end
    dispatch(OP_LW, 5'd26, 32'd0, 32'hA00, 5'd0, 32'd0, 5'd0);
    iEX_en = 1'b1; iEX_nick = 5'd9; iEX_dt = 32'h400;
    tick();
    iEX_en = 1'b0;
    mem_respond(10, 32'h0, ok, a, w, l, d);
    tests_run++;
    if (!ok || a !== 32'h400 || oROB_nick !== 5'd10 || oINF_full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_pop: ok %0b addr %h nick %0d full %0b expected 1 00000400 10 0",
               ok, a, oROB_nick, oINF_full);
    end
    dispatch(OP_LW, 5'd27, 32'd0, 32'h900, 5'd0, 32'd0, 5'd0);
    for (int k = 1; k < 16; k++) begin
      mem_respond(10, 32'h0, ok, a, w, l, d);
      tests_run++;
      if (!ok || a !== 32'h400 + 32'(4 * k) || oROB_nick !== 5'(10 + k)) begin
        tests_failed++;
        $display("[TB] FAIL full_order_%0d: ok %0b addr %h nick %0d expected 1 %h %0d",
                 k, ok, a, oROB_nick, 32'h400 + 32'(4 * k), 10 + k);
      end
    end
    mem_respond(10, 32'h0, ok, a, w, l, d);
    tests_run++;
    if (!ok || a !== 32'h900 || oROB_nick !== 5'd27) begin
      tests_failed++;
      $display("[TB] FAIL full_wrap: ok %0b addr %h nick %0d expected 1 00000900 27", ok, a, oROB_nick);
    end
    mem_respond(5, 32'h0, ok, a, w, l, d);
    tests_run++;
    if (ok) begin
      tests_failed++;
      $display("[TB] FAIL full_ignored: got request addr %h, expected none", a);
    end
  endtask

  task automatic test_rdy();
    bit ok; logic [31:0] a, d; logic w; logic [1:0] l;
    rdy = 1'b0;
    dispatch(OP_LW, 5'd16, 32'd0, 32'hB00, 5'd0, 32'd0, 5'd0);
    tick(); tick();
    tests_run++;
    if (oMC_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rdy_freeze: mc_en %0b expected 0", oMC_en);
    end
    rdy = 1'b1;
    mem_respond(5, 32'h0, ok, a, w, l, d);
    tests_run++;
    if (ok) begin
      tests_failed++;
      $display("[TB] FAIL rdy_dispatch_ignored: got request addr %h, expected none", a);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_back_to_back();
    test_store();
    test_forward();
    test_clear();
    test_full();
    test_rdy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
